// File: rtl/hwpe_stream_addressgen_nd_pkg.sv
// hwpe_stream_package: shared ctrl/flags structs and FSM state for the N-dimensional address generator
package hwpe_stream_package;
  localparam int unsigned ADDRGEN_MAX_DIM = 4;
  localparam int unsigned ADDRGEN_CNT_W = 16;
  localparam int unsigned ADDRGEN_AW = 32;
  typedef struct packed {
    logic [ADDRGEN_AW-1:0] base_addr;
    logic [ADDRGEN_MAX_DIM-1:0][ADDRGEN_CNT_W-1:0] len;
    logic [ADDRGEN_MAX_DIM-1:0][ADDRGEN_AW-1:0] stride;
  } ctrl_addressgen_nd_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic [ADDRGEN_MAX_DIM-1:0] dim_update;
  } flags_addressgen_nd_t;
  typedef enum logic [1:0] {ADDRGEN_IDLE, ADDRGEN_RUN, ADDRGEN_DONE} addrgen_state_e;
endpackage

// File: rtl/hwpe_stream_addressgen_nd_dim.sv
// hwpe_stream_addressgen_nd_dim: one loop dimension, counter plus byte offset, wraps to zero after len_i steps
module hwpe_stream_addressgen_nd_dim #(
  parameter int unsigned CNT = 16,
  parameter int unsigned AW = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           en_i,
  input  logic [CNT-1:0] len_i,
  input  logic [AW-1:0]  inc_i,
  output logic [CNT-1:0] cnt_o,
  output logic [AW-1:0]  off_o,
  output logic           last_o
);
  logic [CNT-1:0] cnt_q, cnt_d;
  logic [AW-1:0] off_q, off_d;
  always_comb begin
    last_o = cnt_q == len_i - 1'b1;
    cnt_d = clear_i ? '0 : !en_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;
    off_d = clear_i ? '0 : !en_i ? off_q : last_o ? '0 : off_q + inc_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  assign cnt_o = cnt_q;
  assign off_o = off_q;
endmodule

// File: rtl/hwpe_stream_addressgen_nd.sv
// hwpe_stream_addressgen_nd: nested-loop word address generator; HWPE_STREAM_ADDRESSGEN_ND_REALIGN_EN adds misaligned-line strobes
module hwpe_stream_addressgen_nd
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_DIM = 3,
  parameter int unsigned STEP = 4,
  parameter int unsigned CNT = 16,
  parameter int unsigned AW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  ctrl_addressgen_nd_t  ctrl_i,
  output logic [AW-1:0]        addr_o,
  output logic [STEP-1:0]      strb_o,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  output flags_addressgen_nd_t flags_o
);
  localparam logic [AW-1:0] AMSK = AW'(STEP - 1);
  addrgen_state_e state_q, state_d;
  logic [AW-1:0] base_q, base_d, line, full;
  logic [NB_DIM-1:0][CNT-1:0] len_q, len_d, cnt;
  logic [NB_DIM-1:0][AW-1:0] stride_q, stride_d, off, inc;
  logic [NB_DIM-1:0] en, last;
  logic [CNT-1:0] len0;
  logic [STEP-1:0] sh;
  logic mis_q, mis_d, mis_new, start_ok, zero_len, run, fin;
  assign run = state_q == ADDRGEN_RUN;
  assign len0 = len_q[0] + CNT'(mis_q);
  assign fin = en[NB_DIM-1] & last[NB_DIM-1];
  always_comb begin
    start_ok = state_q == ADDRGEN_IDLE && start_i && !clear_i;
    zero_len = 1'b0;
`ifdef HWPE_STREAM_ADDRESSGEN_ND_REALIGN_EN
    mis_new = |(ctrl_i.base_addr[AW-1:0] & AMSK);
`else
    mis_new = 1'b0;
`endif
    line = base_q;
    for (int d = 0; d < NB_DIM; d++) begin
      zero_len |= ~|ctrl_i.len[d][CNT-1:0];
`ifdef HWPE_STREAM_ADDRESSGEN_ND_REALIGN_EN
      if (d > 0) mis_new |= |(ctrl_i.stride[d][AW-1:0] & AMSK);
`endif
      if (d > 0) line += off[d];
      len_d[d] = start_ok ? ctrl_i.len[d][CNT-1:0] : len_q[d];
      stride_d[d] = start_ok ? ctrl_i.stride[d][AW-1:0] : stride_q[d];
    end
    full = line + off[0];
    base_d = start_ok ? ctrl_i.base_addr[AW-1:0] : base_q;
    mis_d = start_ok ? mis_new : mis_q;
    state_d = clear_i ? ADDRGEN_IDLE : start_ok ? (zero_len ? ADDRGEN_DONE : ADDRGEN_RUN) :
              run ? (fin ? ADDRGEN_DONE : ADDRGEN_RUN) : ADDRGEN_IDLE;
    // partial first/last beats only exist on lines whose start is misaligned
    sh = {STEP{1'b1}} << (line & AMSK);
    strb_o = !run ? '0 : !mis_q ? '1 : cnt[0] == '0 ? sh : last[0] ? ~sh : '1;
    addr_o = run ? full & ~AMSK : '0;
    addr_valid_o = run;
    flags_o = '0;
    flags_o.busy = run;
    flags_o.done = state_q == ADDRGEN_DONE;
    flags_o.dim_update[NB_DIM-1:0] = en;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ADDRGEN_IDLE;
      base_q <= '0;
      len_q <= '0;
      stride_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      stride_q <= stride_d;
      mis_q <= mis_d;
    end
  for (genvar g = 0; g < NB_DIM; g++) begin : g_dim
    if (g == 0) begin : g_first
      assign en[g] = run & addr_ready_i;
      assign inc[g] = AW'(STEP);
    end else begin : g_outer
      assign en[g] = en[g-1] & last[g-1];
      assign inc[g] = stride_q[g];
    end
    hwpe_stream_addressgen_nd_dim #(.CNT(CNT), .AW(AW)) i_dim (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i | start_ok),
      .en_i   (en[g]),
      .len_i  (g == 0 ? len0 : len_q[g]),
      .inc_i  (inc[g]),
      .cnt_o  (cnt[g]),
      .off_o  (off[g]),
      .last_o (last[g])
    );
  end
endmodule
